cs_frame_ctrl: RTL and testbench
================================

CS_FRAME_CTRL -- requirements
Module: cs_frame_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 64: bytes per frame; power of two, 2..256.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: idle-clock limit while loading (used only with FRAME_TIMEOUT_EN).
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port ssel, input, 1: SPI slave select, active-low, already synchronised to clk.
REQ-006 SHALL have port rx_valid, input, 1: one-cycle strobe, received byte on rx_data.
REQ-007 SHALL have port rx_data, input, 8: received byte.
REQ-008 SHALL have port proc_start, output, 1: one-cycle pulse starting the compression engine.
REQ-009 SHALL have port proc_done, input, 1: one-cycle strobe, engine finished.
REQ-010 SHALL have ports eng_we (input, 1), eng_addr (input, log2(DEPTH)), eng_wdata (input, 8), eng_rdata (output, 8): engine buffer port.
REQ-011 SHALL have port tx_data, output, 8: byte presented to the SPI transmitter.
REQ-012 SHALL have port tx_load, output, 1: one-cycle pulse, tx_data valid for the next byte.
REQ-013 SHALL have port tx_sent, input, 1: one-cycle strobe, transmitter consumed current byte.
REQ-014 SHALL have ports state_o (output, 3: state encoding) and frame_done (output, 1: one-cycle pulse, frame fully sent).

Function
REQ-015 SHALL own one DEPTH x 8 byte buffer, single write port, combinational read.
REQ-016 SHALL implement states IDLE=0, LOAD=1, PROC=2, SEND=3, DONE=4; state_o shows current state.
REQ-017 SHALL leave IDLE for LOAD on the first cycle ssel is low; write pointer cleared to 0.
REQ-018 In LOAD, each rx_valid SHALL write rx_data at write pointer and increment it; the DEPTH-th byte moves to PROC next cycle.
REQ-019 rx_valid outside LOAD SHALL be ignored; no buffer write, no pointer change.
REQ-020 On LOAD->PROC SHALL assert proc_start for exactly one cycle, the first PROC cycle.
REQ-021 Buffer ownership SHALL be exclusive: LOAD=receiver, PROC=engine, SEND/DONE/IDLE=transmitter read only; eng_we outside PROC SHALL be ignored.
REQ-022 In PROC, eng_we SHALL write eng_wdata at eng_addr; eng_rdata SHALL equal buffer[eng_addr] same cycle in all states.
REQ-023 proc_done in PROC SHALL move to SEND with read pointer 0; proc_done on the same cycle as eng_we SHALL still commit the write.
REQ-024 SHALL pulse tx_load on the first SEND cycle and one cycle after each tx_sent, while bytes remain; tx_data SHALL equal buffer[read pointer].
REQ-025 tx_sent SHALL increment the read pointer; tx_sent for byte DEPTH-1 SHALL move to DONE, no further tx_load.
REQ-026 DONE SHALL pulse frame_done for one cycle and return to IDLE next cycle.
REQ-027 ssel rising (high) during LOAD or SEND SHALL abort: return to IDLE next cycle, pointers cleared, no frame_done; buffer contents kept.
REQ-028 ssel high during PROC SHALL NOT abort; engine completion is awaited.
REQ-029 Pointer arithmetic SHALL be log2(DEPTH)+1 bits; no wrap-around within a frame.

Reset
REQ-030 rst SHALL force state IDLE, pointers 0, proc_start=0, tx_load=0, frame_done=0, tx_data=buffer[0]; buffer contents not reset.
REQ-031 rst mid-frame SHALL take priority over all strobes that cycle.

Configuration
REQ-032 Macro FRAME_TIMEOUT_EN defined: in LOAD, a counter cleared by each rx_valid SHALL abort to IDLE after TIMEOUT_CYCLES consecutive cycles without rx_valid.
REQ-033 FRAME_TIMEOUT_EN undefined: no timeout counter; LOAD waits indefinitely; all other behaviour identical.

Verification
REQ-034 Full frame: ssel low, 64 rx_valid bytes 0x00..0x3F -> proc_start pulse once; proc_done with no writes -> 64 tx_load, tx_data 0x00..0x3F in order, one frame_done.
REQ-035 Engine write: in PROC write eng_addr=5 eng_wdata=0xA5 same cycle as proc_done -> sixth transmitted byte 0xA5.
REQ-036 Abort: ssel high after 10 bytes -> IDLE next cycle, no proc_start; new frame of 64 bytes completes normally.
REQ-037 Ownership: eng_we pulses in LOAD and SEND, rx_valid in PROC -> buffer unchanged, transmitted data matches loaded data.
REQ-038 Reset: rst asserted during SEND at byte 20 -> IDLE next cycle, all outputs at reset values, no frame_done.
REQ-039 FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=16: 3 bytes then 16 idle cycles -> IDLE; with 15 idle cycles then a byte -> stays LOAD.

Source files
------------

// File: rtl/cs_frame_if.sv
// Bundle of the receiver, engine and transmitter signals around the frame buffer.
// master = peripheral side that drives strobes, slave = cs_frame_ctrl.
interface cs_frame_if #(
    parameter int DEPTH = 64
);
    localparam int AW = $clog2(DEPTH);

    logic          ssel;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          proc_start;
    logic          proc_done;
    logic          eng_we;
    logic [AW-1:0] eng_addr;
    logic [7:0]    eng_wdata;
    logic [7:0]    eng_rdata;
    logic [7:0]    tx_data;
    logic          tx_load;
    logic          tx_sent;
    logic [2:0]    state_o;
    logic          frame_done;

    modport master (
        output ssel, rx_valid, rx_data, proc_done, eng_we, eng_addr, eng_wdata, tx_sent,
        input  proc_start, eng_rdata, tx_data, tx_load, state_o, frame_done
    );

    modport slave (
        input  ssel, rx_valid, rx_data, proc_done, eng_we, eng_addr, eng_wdata, tx_sent,
        output proc_start, eng_rdata, tx_data, tx_load, state_o, frame_done
    );
endinterface

// File: rtl/cs_frame_ctrl.sv
// SPI frame controller: load a frame into one byte buffer, hand it to the engine, send it back.
// Optional LOAD idle timeout is enabled by defining FRAME_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for ssel low, pointers cleared
// LOAD  | receiver owns buffer, rx bytes written at wptr
// PROC  | engine owns buffer, waiting for proc_done
// SEND  | transmitter reads buffer at rptr, one tx_load per byte
// DONE  | frame_done pulse, back to IDLE
module cs_frame_ctrl #(
    parameter int DEPTH          = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic     clk,
    input  logic     rst,
    cs_frame_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cs_frame_ctrl: DEPTH must be a power of two in 2..256");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("cs_frame_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PROC = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] wptr, wptr_nxt;
    logic [PW-1:0] rptr, rptr_nxt;
    logic          proc_start_q, proc_start_nxt;
    logic          tx_load_q, tx_load_nxt;
    logic          buf_we;
    logic [AW-1:0] buf_addr;
    logic [7:0]    buf_wdata;
    logic          tmo_hit;
    logic [7:0]    mem [DEPTH];

`ifdef FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_cnt;

    // Down-counter reloads on every byte; terminal count with no byte this cycle aborts.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= TMO_LOAD;
        end else if (state != LOAD || bus.rx_valid) begin
            tmo_cnt <= TMO_LOAD;
        end else if (tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - TW'(1);
        end
    end

    assign tmo_hit = (state == LOAD) && !bus.rx_valid && (tmo_cnt == '0);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wptr         <= '0;
            rptr         <= '0;
            proc_start_q <= 1'b0;
            tx_load_q    <= 1'b0;
        end else begin
            state        <= state_nxt;
            wptr         <= wptr_nxt;
            rptr         <= rptr_nxt;
            proc_start_q <= proc_start_nxt;
            tx_load_q    <= tx_load_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        wptr_nxt       = wptr;
        rptr_nxt       = rptr;
        proc_start_nxt = 1'b0;
        tx_load_nxt    = 1'b0;
        buf_we         = 1'b0;
        buf_addr       = wptr[AW-1:0];
        buf_wdata      = bus.rx_data;
        unique case (state)
            IDLE: begin
                if (!bus.ssel) begin
                    state_nxt = LOAD;
                    wptr_nxt  = '0;
                    rptr_nxt  = '0;
                end
            end
            LOAD: begin
                if (bus.ssel || tmo_hit) begin
                    state_nxt = IDLE;
                    wptr_nxt  = '0;
                    rptr_nxt  = '0;
                end else if (bus.rx_valid) begin
                    buf_we   = 1'b1;
                    wptr_nxt = wptr + PW'(1);
                    if (wptr == LAST) begin
                        state_nxt      = PROC;
                        proc_start_nxt = 1'b1;
                    end
                end
            end
            PROC: begin
                buf_we    = bus.eng_we;
                buf_addr  = bus.eng_addr;
                buf_wdata = bus.eng_wdata;
                if (bus.proc_done) begin
                    state_nxt   = SEND;
                    rptr_nxt    = '0;
                    tx_load_nxt = 1'b1;
                end
            end
            SEND: begin
                if (bus.ssel) begin
                    state_nxt = IDLE;
                    wptr_nxt  = '0;
                    rptr_nxt  = '0;
                end else if (bus.tx_sent) begin
                    rptr_nxt = rptr + PW'(1);
                    if (rptr == LAST) begin
                        state_nxt = DONE;
                    end else begin
                        tx_load_nxt = 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                wptr_nxt  = '0;
                rptr_nxt  = '0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Buffer is not reset, but a write coinciding with rst is dropped.
    always_ff @(posedge clk) begin
        if (!rst && buf_we) begin
            mem[buf_addr] <= buf_wdata;
        end
    end

    assign bus.proc_start = proc_start_q;
    assign bus.tx_load    = tx_load_q;
    assign bus.frame_done = (state == DONE);
    assign bus.state_o    = state;
    assign bus.tx_data    = mem[rptr[AW-1:0]];
    assign bus.eng_rdata  = mem[bus.eng_addr];
endmodule

// File: tb/tb_cs_frame_ctrl.sv
// Self-checking bench for cs_frame_ctrl: vector table for short sequences, then frame-level
// scenarios checked against a byte-array model of the buffer and pulse counters.
module tb_cs_frame_ctrl;
    localparam int DEPTH = 64;
    localparam int TMO   = 16;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_PROC = 3'd2;
    localparam logic [2:0] S_SEND = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic clk = 1'b0;
    logic rst;

    cs_frame_if #(.DEPTH(DEPTH)) bus ();

    cs_frame_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_ps  = 0;
    int n_tl  = 0;
    int n_fd  = 0;
    logic [7:0] ref_mem [DEPTH];

    always @(negedge clk) begin
        if (bus.proc_start) n_ps++;
        if (bus.tx_load)    n_tl++;
        if (bus.frame_done) n_fd++;
    end

    typedef struct {
        logic       rst;
        logic       ssel;
        logic       rx_valid;
        logic [7:0] rx_data;
        logic       proc_done;
        logic       tx_sent;
        logic [2:0] exp_state;
        logic       exp_ps;
        logic       exp_tl;
        logic       exp_fd;
    } vec_t;

    vec_t vt [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.rx_valid  = 1'b0;
        bus.proc_done = 1'b0;
        bus.eng_we    = 1'b0;
        bus.tx_sent   = 1'b0;
    endtask

    // Random engine writes and receiver strobes that must be ignored outside their owning state.
    task automatic noise(input bit eng, input bit rx);
        if (eng) begin
            bus.eng_we    = 1'($urandom_range(1, 0));
            bus.eng_addr  = AW'($urandom);
            bus.eng_wdata = 8'($urandom);
        end
        if (rx) begin
            bus.rx_valid = 1'($urandom_range(1, 0));
            bus.rx_data  = 8'($urandom);
        end
    endtask

    task automatic load_bytes(input int n, input bit seq_data, input int max_gap);
        bus.ssel = 1'b0;
        cycle();
        check("enter_load", bus.state_o, S_LOAD);
        for (int i = 0; i < n; i++) begin
            int g;
            g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
            for (int j = 0; j < g; j++) begin
                noise(1'b1, 1'b0);
                cycle();
                clr();
            end
            bus.rx_valid = 1'b1;
            bus.rx_data  = seq_data ? 8'(i) : 8'($urandom);
            ref_mem[i]   = bus.rx_data;
            cycle();
            clr();
        end
    endtask

    task automatic full_load(input bit seq_data, input int max_gap);
        int ps0;
        ps0 = n_ps;
        load_bytes(DEPTH, seq_data, max_gap);
        check("load_to_proc", bus.state_o, S_PROC);
        check("proc_start_first", bus.proc_start, 1'b1);
        cycle_guard_ps(ps0);
    endtask

    task automatic cycle_guard_ps(input int ps0);
        check("proc_start_count_pre", n_ps, ps0);
    endtask

    task automatic proc_phase(input int nw, input bit done_write, input logic [AW-1:0] dw_addr,
                              input logic [7:0] dw_data);
        for (int k = 0; k < nw; k++) begin
            bus.eng_we    = 1'b1;
            bus.eng_addr  = AW'($urandom);
            bus.eng_wdata = 8'($urandom);
            ref_mem[bus.eng_addr] = bus.eng_wdata;
            noise(1'b0, 1'b1);
            cycle();
            clr();
            check("eng_rdata", bus.eng_rdata, ref_mem[bus.eng_addr]);
            check("proc_hold", bus.state_o, S_PROC);
        end
        bus.proc_done = 1'b1;
        if (done_write) begin
            bus.eng_we    = 1'b1;
            bus.eng_addr  = dw_addr;
            bus.eng_wdata = dw_data;
            ref_mem[dw_addr] = dw_data;
        end
        cycle();
        clr();
        check("proc_to_send", bus.state_o, S_SEND);
        check("tx_load_first", bus.tx_load, 1'b1);
    endtask

    // stop_kind 0: ssel abort at byte stop_at; 1: rst (with a colliding tx_sent) at byte stop_at.
    task automatic send_frame(input int stop_at, input int stop_kind);
        int tl0, fd0;
        tl0 = n_tl;
        fd0 = n_fd;
        for (int i = 0; i < DEPTH; i++) begin
            int w, gap;
            w = 0;
            while (!bus.tx_load && w < 4) begin
                cycle();
                w++;
            end
            check("tx_load_seen", bus.tx_load, 1'b1);
            check($sformatf("tx_data[%0d]", i), bus.tx_data, ref_mem[i]);
            if (i == stop_at) begin
                if (stop_kind == 0) begin
                    bus.ssel = 1'b1;
                    cycle();
                    check("abort_send_state", bus.state_o, S_IDLE);
                    check("abort_send_tx_load", bus.tx_load, 1'b0);
                end else begin
                    rst = 1'b1;
                    bus.tx_sent = 1'b1;
                    cycle();
                    rst = 1'b0;
                    clr();
                    check("rst_state", bus.state_o, S_IDLE);
                    check("rst_tx_load", bus.tx_load, 1'b0);
                    check("rst_proc_start", bus.proc_start, 1'b0);
                    check("rst_frame_done", bus.frame_done, 1'b0);
                    check("rst_tx_data", bus.tx_data, ref_mem[0]);
                    bus.ssel = 1'b1;
                end
                cycle();
                cycle();
                check("stop_idle", bus.state_o, S_IDLE);
                check("stop_no_frame_done", n_fd, fd0);
                return;
            end
            gap = $urandom_range(2, 0);
            for (int j = 0; j < gap; j++) begin
                noise(1'b1, 1'b1);
                cycle();
                clr();
            end
            bus.tx_sent = 1'b1;
            cycle();
            clr();
        end
        check("send_to_done", bus.state_o, S_DONE);
        check("frame_done_pulse", bus.frame_done, 1'b1);
        bus.ssel = 1'b1;
        cycle();
        check("done_to_idle", bus.state_o, S_IDLE);
        check("frame_done_low", bus.frame_done, 1'b0);
        check("tx_load_count", n_tl - tl0, DEPTH);
        check("frame_done_count", n_fd - fd0, 1);
    endtask

    task automatic whole_frame(input bit seq_data, input int max_gap, input int nw);
        int ps0;
        ps0 = n_ps;
        full_load(seq_data, max_gap);
        proc_phase(nw, 1'b0, '0, 8'h00);
        send_frame(-1, 0);
        check("proc_start_count", n_ps - ps0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.ssel      = 1'b1;
        bus.rx_data   = 8'h00;
        bus.eng_addr  = '0;
        bus.eng_wdata = 8'h00;
        clr();

        //           rst   ssel  rxv   data   pdone tsent state   ps    tl    fd
        vt[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, S_IDLE, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, S_IDLE, 1'b0, 1'b0, 1'b0};
        vt[2] = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, S_LOAD, 1'b0, 1'b0, 1'b0};
        vt[3] = '{1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, S_LOAD, 1'b0, 1'b0, 1'b0};
        vt[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, S_LOAD, 1'b0, 1'b0, 1'b0};
        vt[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, S_IDLE, 1'b0, 1'b0, 1'b0};
        vt[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, S_IDLE, 1'b0, 1'b0, 1'b0};
        vt[7] = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, S_IDLE, 1'b0, 1'b0, 1'b0};
        vt[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, S_LOAD, 1'b0, 1'b0, 1'b0};
        vt[9] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, S_IDLE, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 10; i++) begin
            rst           = vt[i].rst;
            bus.ssel      = vt[i].ssel;
            bus.rx_valid  = vt[i].rx_valid;
            bus.rx_data   = vt[i].rx_data;
            bus.proc_done = vt[i].proc_done;
            bus.tx_sent   = vt[i].tx_sent;
            cycle();
            check($sformatf("vec%0d_state", i), bus.state_o, vt[i].exp_state);
            check($sformatf("vec%0d_proc_start", i), bus.proc_start, vt[i].exp_ps);
            check($sformatf("vec%0d_tx_load", i), bus.tx_load, vt[i].exp_tl);
            check($sformatf("vec%0d_frame_done", i), bus.frame_done, vt[i].exp_fd);
        end
        rst = 1'b0;
        clr();
        bus.eng_addr = '0;
        #1;
        check("first_byte_at_addr0", bus.eng_rdata, 8'h22);

        // Full frame of 0x00..0x3F, immediate proc_done with no writes.
        whole_frame(1'b1, 0, 0);

        // Engine write on the same cycle as proc_done lands in the sixth byte.
        begin
            int ps0;
            ps0 = n_ps;
            full_load(1'b0, 0);
            proc_phase(0, 1'b1, AW'(5), 8'hA5);
            check("eng_write_model", ref_mem[5], 8'hA5);
            send_frame(-1, 0);
            check("eng_write_proc_start", n_ps - ps0, 1);
        end

        // Abort in LOAD after 10 bytes, then a clean frame.
        begin
            int ps0;
            ps0 = n_ps;
            load_bytes(10, 1'b0, 0);
            bus.ssel = 1'b1;
            cycle();
            check("abort_load_state", bus.state_o, S_IDLE);
            cycle();
            check("abort_load_no_proc_start", n_ps, ps0);
            whole_frame(1'b0, 1, 0);
        end

        // Ownership: eng_we in LOAD/SEND and rx_valid in PROC are all ignored.
        whole_frame(1'b0, 2, 4);

        // Reset during SEND at byte 20.
        full_load(1'b0, 0);
        proc_phase(2, 1'b0, '0, 8'h00);
        send_frame(20, 1);

        // ssel abort during SEND at byte 7.
        full_load(1'b0, 1);
        proc_phase(1, 1'b0, '0, 8'h00);
        send_frame(7, 0);

`ifdef FRAME_TIMEOUT_EN
        load_bytes(3, 1'b0, 0);
        for (int j = 0; j < TMO - 1; j++) cycle();
        check("tmo_15_idle_stays", bus.state_o, S_LOAD);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h5C;
        ref_mem[3]   = 8'h5C;
        cycle();
        clr();
        check("tmo_byte_stays", bus.state_o, S_LOAD);
        for (int j = 0; j < TMO - 1; j++) cycle();
        check("tmo_15_idle_again", bus.state_o, S_LOAD);
        cycle();
        check("tmo_16_idle_abort", bus.state_o, S_IDLE);
        bus.ssel = 1'b1;
        cycle();
        check("tmo_idle_after", bus.state_o, S_IDLE);
`else
        load_bytes(3, 1'b0, 0);
        for (int j = 0; j < 3 * TMO; j++) cycle();
        check("no_tmo_stays_load", bus.state_o, S_LOAD);
        bus.ssel = 1'b1;
        cycle();
        check("no_tmo_abort", bus.state_o, S_IDLE);
`endif

        // Randomised frames with engine rewrites and noise on every phase.
        for (int f = 0; f < 3; f++) begin
            whole_frame(1'b0, 2, $urandom_range(8, 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
